traffic_light_monitor: RTL and testbench

//  Receive-side checker for the 3-bit traffic-light bus {Red,Yellow,Green} driven by the light controller.

---
 rtl/traffic_light_monitor.sv | 150 +++++++++++++++
 tb/tb_traffic_light_monitor.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the one-hot {Red,Yellow,Green} light bus: decodes phase, times it, flags errors.
// Optional build macro TL_MON_CYCLE_CNT_EN enables the completed-round counter on cycle_cnt.
module traffic_light_monitor #(
  parameter int CNT_W     = 8,
  parameter int MAX_PHASE = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       light,
  input  logic             clear_err,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic             phase_change,
  output logic [CNT_W-1:0] last_dur,
  output logic             err_encoding,
  output logic             err_sequence,
  output logic             err_timeout,
  output logic [15:0]      cycle_cnt
);

  typedef enum logic {SYNC, TRACK} state_t;
  typedef enum logic [1:0] {
    PH_RED     = 2'b00,
    PH_GREEN   = 2'b01,
    PH_YELLOW  = 2'b10,
    PH_INVALID = 2'b11
  } phase_t;

  localparam logic [CNT_W-1:0] DUR_MAX   = '1;
  localparam logic [CNT_W-1:0] DUR_LIMIT = CNT_W'(MAX_PHASE);
  localparam logic [CNT_W-1:0] DUR_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  phase_t           sample_ph, next_ph;
  logic             sample_ok;
  logic             phase_valid_q, phase_valid_d;
  logic             phase_change_q, phase_change_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [CNT_W-1:0] last_dur_q, last_dur_d;
  logic             err_encoding_q, err_encoding_d;
  logic             err_sequence_q, err_sequence_d;
  logic             err_timeout_q, err_timeout_d;
  logic             enc_set, seq_set, to_set;

  always_comb begin
    sample_ok = 1'b1;
    sample_ph = PH_INVALID;
    case (light)
      3'b100:  sample_ph = PH_RED;
      3'b001:  sample_ph = PH_GREEN;
      3'b010:  sample_ph = PH_YELLOW;
      default: sample_ok = 1'b0;
    endcase
    case (phase_q)
      PH_RED:   next_ph = PH_GREEN;
      PH_GREEN: next_ph = PH_YELLOW;
      default:  next_ph = PH_RED;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    phase_valid_d  = phase_valid_q;
    phase_change_d = 1'b0;
    dur_d          = dur_q;
    last_dur_d     = last_dur_q;
    enc_set        = 1'b0;
    seq_set        = 1'b0;
    to_set         = 1'b0;
    if (!sample_ok) begin
      enc_set       = 1'b1;
      phase_d       = PH_INVALID;
      phase_valid_d = 1'b0;
      dur_d         = '0;
      state_d       = SYNC;
    end else if (state_q == SYNC) begin
      phase_d       = sample_ph;
      phase_valid_d = 1'b1;
      dur_d         = DUR_ONE;
      state_d       = TRACK;
    end else if (sample_ph == phase_q) begin
      if (dur_q == DUR_LIMIT) to_set = 1'b1;
      if (dur_q != DUR_MAX) dur_d = dur_q + 1'b1;
    end else begin
      // Any phase change resyncs to the observed phase; only the order check differs.
      phase_change_d = 1'b1;
      last_dur_d     = dur_q;
      dur_d          = DUR_ONE;
      phase_d        = sample_ph;
      if (sample_ph != next_ph) seq_set = 1'b1;
    end
    err_encoding_d = (err_encoding_q & ~clear_err) | enc_set;
    err_sequence_d = (err_sequence_q & ~clear_err) | seq_set;
    err_timeout_d  = (err_timeout_q  & ~clear_err) | to_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= SYNC;
      phase_q        <= PH_INVALID;
      phase_valid_q  <= 1'b0;
      phase_change_q <= 1'b0;
      dur_q          <= '0;
      last_dur_q     <= '0;
      err_encoding_q <= 1'b0;
      err_sequence_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      phase_valid_q  <= phase_valid_d;
      phase_change_q <= phase_change_d;
      dur_q          <= dur_d;
      last_dur_q     <= last_dur_d;
      err_encoding_q <= err_encoding_d;
      err_sequence_q <= err_sequence_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

`ifdef TL_MON_CYCLE_CNT_EN
  logic [15:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (state_q == TRACK && sample_ok && phase_q == PH_YELLOW && sample_ph == PH_RED)
      cycle_cnt_d = cycle_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cycle_cnt_q <= '0;
    else       cycle_cnt_q <= cycle_cnt_d;
  end

  assign cycle_cnt = cycle_cnt_q;
`else
  assign cycle_cnt = 16'h0;
`endif

  assign phase        = phase_q;
  assign phase_valid  = phase_valid_q;
  assign phase_change = phase_change_q;
  assign last_dur     = last_dur_q;
  assign err_encoding = err_encoding_q;
  assign err_sequence = err_sequence_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: two instances (default and CNT_W=4/MAX_PHASE=5) against a round-order model.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] light = 3'b000;
  logic       clear_err = 1'b0;

  logic [1:0]  a_phase, b_phase;
  logic        a_valid, b_valid, a_chg, b_chg;
  logic [7:0]  a_last;
  logic [3:0]  b_last;
  logic        a_enc, b_enc, a_seq, b_seq, a_to, b_to;
  logic [15:0] a_cyc, b_cyc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  traffic_light_monitor dut_a (
    .clk(clk), .reset(reset), .light(light), .clear_err(clear_err),
    .phase(a_phase), .phase_valid(a_valid), .phase_change(a_chg), .last_dur(a_last),
    .err_encoding(a_enc), .err_sequence(a_seq), .err_timeout(a_to), .cycle_cnt(a_cyc)
  );

  traffic_light_monitor #(.CNT_W(4), .MAX_PHASE(5)) dut_b (
    .clk(clk), .reset(reset), .light(light), .clear_err(clear_err),
    .phase(b_phase), .phase_valid(b_valid), .phase_change(b_chg), .last_dur(b_last),
    .err_encoding(b_enc), .err_sequence(b_seq), .err_timeout(b_to), .cycle_cnt(b_cyc)
  );

  // Reference: round position 0=Red 1=Green 2=Yellow; successor is (pos+1) mod 3.
  int m_ph[2], m_dur[2], m_last[2], m_cyc[2];
  bit m_valid[2], m_chg[2], m_enc[2], m_seq[2], m_to[2], m_trk[2];
  int cmax[2] = '{255, 15};
  int maxp[2] = '{200, 5};
  logic [2:0] ph_light[3] = '{3'b100, 3'b001, 3'b010};
  logic [2:0] bad_light[5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pos_of(input logic [2:0] l);
    for (int k = 0; k < 3; k++) if (ph_light[k] == l) return k;
    return -1;
  endfunction

  task automatic model(input int i, input logic [2:0] l, input bit clr, input bit rst);
    int p;
    bit s_enc, s_seq, s_to;
    if (rst) begin
      m_ph[i] = 3; m_valid[i] = 0; m_chg[i] = 0; m_last[i] = 0; m_dur[i] = 0;
      m_enc[i] = 0; m_seq[i] = 0; m_to[i] = 0; m_cyc[i] = 0; m_trk[i] = 0;
      return;
    end
    p = pos_of(l);
    s_enc = 0; s_seq = 0; s_to = 0;
    m_chg[i] = 0;
    if (p < 0) begin
      s_enc = 1; m_ph[i] = 3; m_valid[i] = 0; m_dur[i] = 0; m_trk[i] = 0;
    end else if (!m_trk[i]) begin
      m_ph[i] = p; m_valid[i] = 1; m_dur[i] = 1; m_trk[i] = 1;
    end else if (p == m_ph[i]) begin
      if (m_dur[i] == maxp[i]) s_to = 1;
      if (m_dur[i] < cmax[i]) m_dur[i]++;
    end else begin
      m_chg[i] = 1; m_last[i] = m_dur[i]; m_dur[i] = 1;
      if (p != (m_ph[i] + 1) % 3) s_seq = 1;
`ifdef TL_MON_CYCLE_CNT_EN
      else if (m_ph[i] == 2) m_cyc[i] = (m_cyc[i] + 1) % 65536;
`endif
      m_ph[i] = p;
    end
    m_enc[i] = (m_enc[i] && !clr) || s_enc;
    m_seq[i] = (m_seq[i] && !clr) || s_seq;
    m_to[i]  = (m_to[i]  && !clr) || s_to;
  endtask

  task automatic cmp(input int i, input int unsigned ph, input bit vld, input bit chg,
                     input int unsigned last, input bit enc, input bit seq, input bit to,
                     input int unsigned cyc);
    string s;
    s = (i == 0) ? "a" : "b";
    check({s, ".phase"}, ph, m_ph[i]);
    check({s, ".phase_valid"}, vld, m_valid[i]);
    check({s, ".phase_change"}, chg, m_chg[i]);
    check({s, ".last_dur"}, last, m_last[i]);
    check({s, ".err_encoding"}, enc, m_enc[i]);
    check({s, ".err_sequence"}, seq, m_seq[i]);
    check({s, ".err_timeout"}, to, m_to[i]);
    check({s, ".cycle_cnt"}, cyc, m_cyc[i]);
  endtask

  task automatic step(input logic [2:0] l, input bit clr, input bit rst);
    @(negedge clk);
    light = l; clear_err = clr; reset = rst;
    @(posedge clk);
    model(0, l, clr, rst);
    model(1, l, clr, rst);
    #1;
    cmp(0, a_phase, a_valid, a_chg, a_last, a_enc, a_seq, a_to, a_cyc);
    cmp(1, b_phase, b_valid, b_chg, b_last, b_enc, b_seq, b_to, b_cyc);
  endtask

  task automatic hold(input logic [2:0] l, input int n);
    for (int k = 0; k < n; k++) step(l, 1'b0, 1'b0);
  endtask

  initial begin
    int last_pos, p, len, r;
    logic [2:0] l;
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b1);
    // Basic round R3 G4 Y2 R1
    hold(3'b100, 3); hold(3'b001, 4); hold(3'b010, 2); hold(3'b100, 1);
    // Out-of-order R->Y, then clear
    hold(3'b100, 1); hold(3'b010, 2);
    step(3'b010, 1'b1, 1'b0);
    hold(3'b010, 1);
    // Bad encoding then resync on green
    hold(3'b110, 1); hold(3'b001, 2);
    // Timeout and saturation on the narrow instance
    hold(3'b100, 20); hold(3'b001, 2);
    // Clear coinciding with an illegal G->R
    step(3'b100, 1'b1, 1'b0);
    hold(3'b100, 1);
    // Reset while tracking green
    hold(3'b001, 3);
    step(3'b001, 1'b0, 1'b1);
    hold(3'b010, 2); hold(3'b100, 2);
    // Long red for wide-instance timeout and saturation
    step(3'b100, 1'b1, 1'b0);
    hold(3'b100, 260); hold(3'b001, 1);
    last_pos = 1;
    for (int seg = 0; seg < 300; seg++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      begin p = (last_pos + 1) % 3; l = ph_light[p]; last_pos = p; end
      else if (r < 85) begin p = (last_pos + 2) % 3; l = ph_light[p]; last_pos = p; end
      else             l = bad_light[$urandom_range(0, 4)];
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 20) : $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        step(l, ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
